// File: rtl/sprite_pipe.sv
// -----------------------------------------------------------------------------
// sprite_pipe
//
// Pipelined tile-sprite pixel generator. For each pixel coordinate it picks a
// sprite code out of a packed row-of-slots word, drives the external sprite
// ROM address, extracts the pixel's palette index from the returned ROM row
// and resolves it through a writable 2^BPP-entry RGB888 palette.
//
// Latency is L = ROM_LATENCY + 2 register stages from the capture of a
// coordinate to the outputs: stage 1 drives rom_addr, ROM_LATENCY delay stages
// follow the ROM, and the final stage does pixel select and palette lookup.
// Throughput is one pixel per clock with no stalls.
//
// Optional feature macro: SPRITE_FLIP_EN
//   When defined, each slot code carries an extra MSB that mirrors the tile
//   horizontally (effective column = T-1-col).
//
// Ports
//   clk           pixel clock, all state on rising edge
//   rst           asynchronous active-high reset
//   x, y          12-bit pixel coordinate
//   in_valid      coordinate valid this cycle
//   slot_codes    SLOTS packed codes, slot k at [k*CODE_W +: CODE_W]
//   rom_addr      registered ROM address {sprite index, tile row}
//   rom_data      ROM row, T pixels of BPP bits, column 0 at the MSBs
//   pal_we        palette write strobe
//   pal_idx       palette entry to write
//   pal_data      RGB888 write data
//   out_valid     output pixel valid
//   tile_x/tile_y tile coordinates aligned with out_valid
//   sprite_on     palette index of the pixel is non-zero
//   sprite_color  palette colour of the pixel (0 when out_valid is 0)
// -----------------------------------------------------------------------------
module sprite_pipe #(
   parameter int TILE_LOG2   = 5,
   parameter int BPP         = 3,
   parameter int IDX_W       = 4,
   parameter int SLOTS       = 8,
   parameter int ROM_LATENCY = 1,
`ifdef SPRITE_FLIP_EN
   localparam int CODE_W     = IDX_W + 1,
`else
   localparam int CODE_W     = IDX_W,
`endif
   localparam int T          = 2 ** TILE_LOG2,
   localparam int TX_W       = 12 - TILE_LOG2,
   localparam int AW         = IDX_W + TILE_LOG2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [11:0]               x,
   input  logic [11:0]               y,
   input  logic                      in_valid,
   input  logic [SLOTS*CODE_W-1:0]   slot_codes,
   output logic [AW-1:0]             rom_addr,
   input  logic [T*BPP-1:0]          rom_data,
   input  logic                      pal_we,
   input  logic [BPP-1:0]            pal_idx,
   input  logic [23:0]               pal_data,
   output logic                      out_valid,
   output logic [TX_W-1:0]           tile_x,
   output logic [TX_W-1:0]           tile_y,
   output logic                      sprite_on,
   output logic [23:0]               sprite_color
);

   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   // Per-pixel side information that must travel alongside the ROM access.
   typedef struct packed {
      logic                 valid;
      logic [TX_W-1:0]      tile_x;
      logic [TX_W-1:0]      tile_y;
      logic [TILE_LOG2-1:0] col;
`ifdef SPRITE_FLIP_EN
      logic                 flip;
`endif
   } stage_t;

   logic [SLOT_W-1:0]    slot_c;
   logic [CODE_W-1:0]    code_c;
   stage_t               stage0_c;
   stage_t               pipe [ROM_LATENCY+1];
   stage_t               last_c;
   logic [TILE_LOG2-1:0] eff_col_c;
   logic [TILE_LOG2-1:0] sel_c;
   logic [BPP-1:0]       pix_c;
   logic [23:0]          palette [2**BPP];

   // ---------------------------------------------------------------- stage 0
   // NOTE: every always_comb output gets a value before any condition so the
   // block can never hold state and infer a latch.
   always_comb begin
      // Coordinates past SLOTS*T simply wrap around the slot row.
      slot_c          = SLOT_W'(32'(x[11:TILE_LOG2]) % SLOTS);
      code_c          = slot_codes[slot_c*CODE_W +: CODE_W];
      stage0_c        = '0;
      stage0_c.valid  = in_valid;
      stage0_c.tile_x = x[11:TILE_LOG2];
      stage0_c.tile_y = y[11:TILE_LOG2];
      stage0_c.col    = x[TILE_LOG2-1:0];
`ifdef SPRITE_FLIP_EN
      stage0_c.flip   = code_c[CODE_W-1];
`endif
   end

   // ------------------------------------------- stage 1 + ROM delay pipeline
   // pipe[0] is captured together with rom_addr; pipe[ROM_LATENCY] lines up
   // with the rom_data that answers that address.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and the shift pipeline moves one stage per clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr <= '0;
         for (int i = 0; i <= ROM_LATENCY; i++) pipe[i] <= '0;
      end else begin
         rom_addr <= {code_c[IDX_W-1:0], y[TILE_LOG2-1:0]};
         pipe[0]  <= stage0_c;
         for (int i = 1; i <= ROM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   // --------------------------------------------------- pixel select (comb)
   always_comb begin
      last_c    = pipe[ROM_LATENCY];
      eff_col_c = last_c.col;
`ifdef SPRITE_FLIP_EN
      if (last_c.flip) eff_col_c = ~last_c.col;   // T-1-col
`endif
      // Column 0 sits at the MSBs, so column c lives in slice T-1-c, which is
      // the bitwise inverse of c at TILE_LOG2 bits. Kept as its own signal so
      // the inversion is not widened by the multiply below.
      sel_c = ~eff_col_c;
      pix_c = rom_data[sel_c*BPP +: BPP];
   end

   // ----------------------------------------- stage L: lookup and palette
   // NOTE: the palette is a small register file that must read as all-zero
   // after reset, so unlike a RAM it is cleared by the reset branch.
   // Because the lookup and the write are on the same edge, the lookup sees
   // the old entry (read-before-write) without any bypass logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         tile_x       <= '0;
         tile_y       <= '0;
         sprite_on    <= 1'b0;
         sprite_color <= '0;
         for (int i = 0; i < 2**BPP; i++) palette[i] <= '0;
      end else begin
         out_valid    <= last_c.valid;
         tile_x       <= last_c.tile_x;
         tile_y       <= last_c.tile_y;
         // Index 0 is still looked up; only sprite_on marks it transparent.
         sprite_on    <= last_c.valid && (pix_c != '0);
         sprite_color <= last_c.valid ? palette[pix_c] : 24'h000000;
         if (pal_we) palette[pal_idx] <= pal_data;
      end
   end

endmodule

// File: tb/tb_sprite_pipe.sv
// -----------------------------------------------------------------------------
// tb_sprite_pipe
//
// Self-checking bench for sprite_pipe. A behavioural model computes every
// pixel's expected result from the coordinate, the slot word, the ROM image
// and a model palette, and holds it in a queue until it is due at the outputs.
// A negedge compare process checks the DUT against it every cycle; directed
// sequences add literal expectations for the documented corner cases.
// Build with SPRITE_FLIP_EN defined to exercise the flip variant (the bench
// then also uses a 2-cycle ROM).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprite_pipe;

   localparam int TILE_LOG2 = 5;
   localparam int BPP       = 3;
   localparam int IDX_W     = 4;
   localparam int SLOTS     = 8;
`ifdef SPRITE_FLIP_EN
   localparam int ROM_LAT   = 2;
   localparam int CODE_W    = IDX_W + 1;
`else
   localparam int ROM_LAT   = 1;
   localparam int CODE_W    = IDX_W;
`endif
   localparam int T    = 2 ** TILE_LOG2;
   localparam int L    = ROM_LAT + 2;
   localparam int AW   = IDX_W + TILE_LOG2;
   localparam int RW   = T * BPP;
   localparam int TX_W = 12 - TILE_LOG2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [11:0]             x, y;
   logic                    in_valid;
   logic [SLOTS*CODE_W-1:0] slot_codes;
   logic [AW-1:0]           rom_addr;
   logic [RW-1:0]           rom_data;
   logic                    pal_we;
   logic [BPP-1:0]          pal_idx;
   logic [23:0]             pal_data;
   logic                    out_valid;
   logic [TX_W-1:0]         tile_x, tile_y;
   logic                    sprite_on;
   logic [23:0]             sprite_color;

   int n_checks = 0;
   int n_errors = 0;

   sprite_pipe #(
      .TILE_LOG2(TILE_LOG2), .BPP(BPP), .IDX_W(IDX_W),
      .SLOTS(SLOTS), .ROM_LATENCY(ROM_LAT)
   ) dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .in_valid(in_valid),
      .slot_codes(slot_codes), .rom_addr(rom_addr), .rom_data(rom_data),
      .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
      .out_valid(out_valid), .tile_x(tile_x), .tile_y(tile_y),
      .sprite_on(sprite_on), .sprite_color(sprite_color)
   );

   always #5 clk = ~clk;

   // ----------------------------------------------------------- ROM model
   logic [RW-1:0] rom_mem [2**AW];
   logic [RW-1:0] rom_q   [ROM_LAT];

   always @(posedge clk) begin
      rom_q[0] <= rom_mem[rom_addr];
      for (int i = 1; i < ROM_LAT; i++) rom_q[i] <= rom_q[i-1];
   end
   assign rom_data = rom_q[ROM_LAT-1];

   // ---------------------------------------------------------- check task
   task automatic check(input string name, input logic [95:0] act,
                        input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // --------------------------------------------------- behavioural model
   typedef struct {
      bit valid;
      int tx;
      int ty;
      int pix;
   } ent_t;

   ent_t       q[$];
   bit [23:0]  m_pal [2**BPP];
   bit         exp_valid, exp_on;
   bit [23:0]  exp_color;
   int         exp_tx, exp_ty, exp_addr;

   function automatic int code_of(input logic [SLOTS*CODE_W-1:0] codes, input int xx);
      int slot;
      slot = (xx / T) % SLOTS;
      return int'((codes >> (slot * CODE_W)) & ((1 << CODE_W) - 1));
   endfunction

   function automatic int addr_of(input logic [SLOTS*CODE_W-1:0] codes, input int xx, input int yy);
      return (code_of(codes, xx) % (1 << IDX_W)) * T + (yy % T);
   endfunction

   function automatic int pix_of(input logic [SLOTS*CODE_W-1:0] codes, input int xx, input int yy);
      int            col;
      logic [RW-1:0] rowbits;
      col = xx % T;
`ifdef SPRITE_FLIP_EN
      if (((code_of(codes, xx) >> IDX_W) & 1) == 1) col = T - 1 - col;
`endif
      rowbits = rom_mem[addr_of(codes, xx, yy)];
      return int'((rowbits >> ((T - 1 - col) * BPP)) & ((1 << BPP) - 1));
   endfunction

   // Entry pushed on capture edge m is what the outputs show after edge
   // m+L-1; palette writes on an edge are applied after that edge's lookup.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         exp_valid = 0; exp_on = 0; exp_color = '0;
         exp_tx = 0; exp_ty = 0; exp_addr = 0;
         for (int i = 0; i < 2**BPP; i++) m_pal[i] = '0;
      end else begin
         ent_t e, h;
         e.valid  = in_valid;
         e.tx     = int'(x) / T;
         e.ty     = int'(y) / T;
         e.pix    = pix_of(slot_codes, int'(x), int'(y));
         exp_addr = addr_of(slot_codes, int'(x), int'(y));
         q.push_back(e);
         if (q.size() >= L) begin
            h         = q.pop_front();
            exp_valid = h.valid;
            exp_tx    = h.tx;
            exp_ty    = h.ty;
            exp_on    = h.valid && (h.pix != 0);
            exp_color = h.valid ? m_pal[h.pix] : 24'h0;
         end else begin
            exp_valid = 0; exp_on = 0; exp_color = '0;
         end
         if (pal_we) m_pal[pal_idx] = pal_data;
      end
   end

   // ------------------------------------------------------ compare process
   always @(negedge clk) begin
      if (!rst) begin
         check("out_valid", 96'(out_valid), 96'(exp_valid));
         check("sprite_on", 96'(sprite_on), 96'(exp_on));
         check("sprite_color", 96'(sprite_color), 96'(exp_color));
         check("rom_addr", 96'(rom_addr), 96'(exp_addr));
         if (exp_valid) begin
            check("tile_x", 96'(tile_x), 96'(exp_tx));
            check("tile_y", 96'(tile_y), 96'(exp_ty));
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   // Inputs change only at negedge; each step consumes one rising edge.
   task automatic step(input bit v, input int xx, input int yy);
      in_valid = v;
      x        = 12'(xx);
      y        = 12'(yy);
      @(posedge clk);
      @(negedge clk);
      pal_we = 1'b0;
   endtask

   task automatic pal_write(input int idx, input logic [23:0] data);
      pal_we   = 1'b1;
      pal_idx  = BPP'(idx);
      pal_data = data;
      step(0, 0, 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_out_valid"}, 96'(out_valid), 96'(0));
      check({tag, "_sprite_on"}, 96'(sprite_on), 96'(0));
      check({tag, "_sprite_color"}, 96'(sprite_color), 96'(0));
      check({tag, "_tile_x"}, 96'(tile_x), 96'(0));
      check({tag, "_tile_y"}, 96'(tile_y), 96'(0));
      check({tag, "_rom_addr"}, 96'(rom_addr), 96'(0));
   endtask

   initial begin
      logic [CODE_W-1:0] c;
      rst = 1'b1; in_valid = 1'b0; x = '0; y = '0;
      pal_we = 1'b0; pal_idx = '0; pal_data = '0;

      for (int i = 0; i < 2**AW; i++)
         rom_mem[i] = RW'({$urandom, $urandom, $urandom});
      rom_mem[67][72 +: 3] = 3'd5;   // sprite 2, row 3, column 7 -> index 5
      rom_mem[67][2:0]     = 3'd6;   // sprite 2, row 3, column 31 -> index 6
      rom_mem[96]          = '0;     // sprite 3, row 0: all transparent

      slot_codes = SLOTS*CODE_W'({$urandom, $urandom});
      slot_codes[0 +: CODE_W]      = CODE_W'(2);
      slot_codes[CODE_W +: CODE_W] = CODE_W'(3);

      // Reset state
      @(negedge clk); @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;

      // Palette setup
      for (int i = 0; i < 2**BPP; i++) pal_write(i, 24'($urandom));
      pal_write(5, 24'hFF8000);
      pal_write(0, 24'h123456);
      pal_write(6, 24'h0A0B0C);

      // First pixel: address after one edge, result after L edges
      step(1, 7, 3);
      check("t1_rom_addr", 96'(rom_addr), 96'('h43));
      for (int i = 1; i < L; i++) step(0, 0, 0);
      check("t1_out_valid", 96'(out_valid), 96'(1));
      check("t1_sprite_on", 96'(sprite_on), 96'(1));
      check("t1_sprite_color", 96'(sprite_color), 96'(24'hFF8000));
      check("t1_tile_x", 96'(tile_x), 96'(0));
      check("t1_tile_y", 96'(tile_y), 96'(0));

      // Alternating valid stream across all slots and the wrap point
      for (int xx = 0; xx <= 256; xx++) begin
         step(xx % 2 == 0, xx, int'($urandom_range(0, 4095)));
         if (xx == 224)
            check("slot7_idx", 96'(rom_addr[AW-1:TILE_LOG2]),
                  96'(slot_codes[7*CODE_W +: IDX_W]));
         if (xx == 256)
            check("wrap_slot0_idx", 96'(rom_addr[AW-1:TILE_LOG2]), 96'(2));
      end
      for (int i = 0; i < L; i++) step(0, 0, 0);

      // Transparent index 0 still looks up palette[0]
      step(1, 32, 0);
      for (int i = 1; i < L; i++) step(0, 0, 0);
      check("idx0_out_valid", 96'(out_valid), 96'(1));
      check("idx0_sprite_on", 96'(sprite_on), 96'(0));
      check("idx0_sprite_color", 96'(sprite_color), 96'(24'h123456));
      step(0, 0, 0);
      check("bubble_out_valid", 96'(out_valid), 96'(0));
      check("bubble_sprite_color", 96'(sprite_color), 96'(0));

      // Palette write on the lookup edge returns the old colour
      step(1, 7, 3);
      for (int i = 2; i < L; i++) step(0, 0, 0);
      pal_we = 1'b1; pal_idx = 3'd5; pal_data = 24'h00FF00;
      step(0, 0, 0);
      check("rbw_old_color", 96'(sprite_color), 96'(24'hFF8000));
      step(1, 7, 3);
      for (int i = 1; i < L; i++) step(0, 0, 0);
      check("rbw_new_color", 96'(sprite_color), 96'(24'h00FF00));

`ifdef SPRITE_FLIP_EN
      // Flipped slot: x=0 reads column 31 (the ROM row's LSBs)
      c = slot_codes[0 +: CODE_W];
      slot_codes[0 +: CODE_W] = {1'b1, 4'd2};
      step(1, 0, 3);
      for (int i = 1; i < L; i++) step(0, 0, 0);
      check("flip_sprite_on", 96'(sprite_on), 96'(1));
      check("flip_sprite_color", 96'(sprite_color), 96'(24'h0A0B0C));
      slot_codes[0 +: CODE_W] = c;
`else
      c = '0;
`endif

      // Randomised traffic with concurrent palette writes
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            pal_we   = 1'b1;
            pal_idx  = BPP'($urandom);
            pal_data = 24'($urandom);
         end
         if ($urandom_range(0, 31) == 0)
            slot_codes = SLOTS*CODE_W'({$urandom, $urandom});
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 4095)));
      end

      // Reset with pixels in flight
      for (int i = 0; i < 3; i++)
         step(1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      #2 rst = 1'b1;
      #1 check_zero_outputs("midrst");
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      step(1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      check("rst_k_out_valid", 96'(out_valid), 96'(0));
      for (int i = 2; i < L; i++) begin
         step(0, 0, 0);
         check("rst_wait_out_valid", 96'(out_valid), 96'(0));
      end
      step(0, 0, 0);
      check("rst_first_out_valid", 96'(out_valid), 96'(1));

      // More random traffic after the palette was cleared
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            pal_we   = 1'b1;
            pal_idx  = BPP'($urandom);
            pal_data = 24'($urandom);
         end
         step($urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 4095)));
      end
      for (int i = 0; i < L; i++) step(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
